// File: rtl/tiny_dnn_pkg.sv
// tiny_dnn_pkg: definitions shared by the parameter-load controller.
//   F_NUM_DEF   default number of tiny_dnn_core instances fed
//   PRM_AW      core weight address width
//   PRM_DW      parameter word width (upper half of a 32-bit stream beat)
//   CORE_IW     core index width
//   prm_state_t load controller states
package tiny_dnn_pkg;

  localparam int F_NUM_DEF = 16;
  localparam int PRM_AW    = 10;
  localparam int PRM_DW    = 16;
  localparam int CORE_IW   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_FIN
  } prm_state_t;

endpackage

// File: rtl/prm_load_ctrl_if.sv
// prm_load_ctrl_if: stream source and core parameter write port.
//   src_valid/src_data/src_last/src_ready  AXI-stream style source beats
//   prm_we/prm_v/prm_a/prm_wd/prm_b        write port to the addressed core
// Modports:
//   master  controller side (accepts beats, issues writes)
//   slave   environment side (supplies beats, receives writes)
interface prm_load_ctrl_if;
  import tiny_dnn_pkg::*;

  logic                 src_valid;
  logic [31:0]          src_data;
  logic                 src_last;
  logic                 src_ready;

  logic                 prm_we;
  logic [CORE_IW-1:0]   prm_v;
  logic [PRM_AW-1:0]    prm_a;
  logic [PRM_DW-1:0]    prm_wd;
  logic                 prm_b;

  modport master (
    input  src_valid, src_data, src_last,
    output src_ready, prm_we, prm_v, prm_a, prm_wd, prm_b
  );

  modport slave (
    output src_valid, src_data, src_last,
    input  src_ready, prm_we, prm_v, prm_a, prm_wd, prm_b
  );

endinterface

// File: rtl/prm_load_ctrl_addr_cnt.sv
// prm_addr_cnt: nested address / core-index counter for parameter loads.
//   clk, rst_n  clock, async active-low reset
//   clr         restart at (core 0, addr 0)
//   adv         step to the next beat position
//   bmode       bias load: address held at 0, core steps every beat
//   ks, nf      last address per filter, last core index
//   addr, core  position of the beat about to be accepted
//   last        current position is the final one of the load
module prm_addr_cnt
  import tiny_dnn_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               adv,
  input  logic               bmode,
  input  logic [PRM_AW-1:0]  ks,
  input  logic [CORE_IW-1:0] nf,
  output logic [PRM_AW-1:0]  addr,
  output logic [CORE_IW-1:0] core,
  output logic               last
);

  logic [PRM_AW-1:0] ks_eff;
  logic              addr_wrap;

  // A bias load is a weight load with one word per filter.
  assign ks_eff    = bmode ? '0 : ks;
  assign addr_wrap = (addr == ks_eff);
  assign last      = addr_wrap && (core == nf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      core <= '0;
    end else if (clr) begin
      addr <= '0;
      core <= '0;
    end else if (adv) begin
      if (addr_wrap) begin
        addr <= '0;
        core <= core + 1'b1;
      end else begin
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/prm_load_ctrl.sv
// prm_load_ctrl: streams weight or bias words into an array of cores.
//   clk, rst_n     clock, async active-low reset
//   start          one-cycle load request, sampled in IDLE only
//   bmode          1 = bias load, 0 = weight load (latched with start)
//   ks             weight words per filter minus 1 (latched)
//   nf             filters minus 1 (latched, capped at F_NUM-1)
//   bus            prm_load_ctrl_if.master: source stream and core write port
//   busy           controller not in IDLE
//   done           one-cycle pulse on return to IDLE after a load
//   err            sticky framing error, cleared by the next accepted start
// Build option: define PRM_LOAD_ERR_EN to enable src_last framing checks.
// Without it src_last is ignored, DRAIN is unreachable and err is 0.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_LOAD  | accepting beats, one core write per accepted beat
// ST_DRAIN | final word written without src_last; discard to src_last
// ST_FIN   | final write on the port; return to IDLE with done
module prm_load_ctrl
  import tiny_dnn_pkg::*;
#(
  parameter int F_NUM = F_NUM_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 bmode,
  input  logic [PRM_AW-1:0]    ks,
  input  logic [CORE_IW-1:0]   nf,
  prm_load_ctrl_if.master      bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  prm_state_t          state;
  logic                bmode_q;
  logic [PRM_AW-1:0]   ks_q;
  logic [CORE_IW-1:0]  nf_q;
  logic [CORE_IW-1:0]  nf_cap;
  logic                nf_over;
  logic                beat;
  logic                cnt_clr;
  logic                cnt_adv;
  logic                cnt_last;
  logic [PRM_AW-1:0]   cnt_addr;
  logic [CORE_IW-1:0]  cnt_core;
  logic                unused_bits;

  // Out-of-range filter counts are clipped to the last existing core.
  assign nf_over = ({{(32-CORE_IW){1'b0}}, nf} >= F_NUM);
  assign nf_cap  = nf_over ? CORE_IW'(F_NUM - 1) : nf;

  assign bus.src_ready = (state == ST_LOAD) || (state == ST_DRAIN);
  assign busy          = (state != ST_IDLE);
  assign beat          = bus.src_valid && bus.src_ready;
  assign cnt_clr       = (state == ST_IDLE) && start;
  assign cnt_adv       = (state == ST_LOAD) && beat;
  assign unused_bits   = ^{bus.src_data[15:0], bus.src_last};

  prm_addr_cnt u_addr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .adv   (cnt_adv),
    .bmode (bmode_q),
    .ks    (ks_q),
    .nf    (nf_q),
    .addr  (cnt_addr),
    .core  (cnt_core),
    .last  (cnt_last)
  );

`ifndef PRM_LOAD_ERR_EN
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bmode_q    <= 1'b0;
      ks_q       <= '0;
      nf_q       <= '0;
      bus.prm_we <= 1'b0;
      bus.prm_v  <= '0;
      bus.prm_a  <= '0;
      bus.prm_wd <= '0;
      bus.prm_b  <= 1'b0;
      done       <= 1'b0;
`ifdef PRM_LOAD_ERR_EN
      err        <= 1'b0;
`endif
    end else begin
      bus.prm_we <= 1'b0;
      done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_LOAD;
            bmode_q   <= bmode;
            ks_q      <= ks;
            nf_q      <= nf_cap;
            bus.prm_b <= bmode;
`ifdef PRM_LOAD_ERR_EN
            err       <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (beat) begin
            bus.prm_we <= 1'b1;
            bus.prm_v  <= cnt_core;
            bus.prm_a  <= cnt_addr;
            bus.prm_wd <= bus.src_data[31:16];
`ifdef PRM_LOAD_ERR_EN
            // Early src_last truncates the load; a missing one drains
            // the rest of the packet without writing it.
            if (cnt_last && !bus.src_last) begin
              err   <= 1'b1;
              state <= ST_DRAIN;
            end else if (cnt_last) begin
              state <= ST_FIN;
            end else if (bus.src_last) begin
              err   <= 1'b1;
              state <= ST_FIN;
            end
`else
            if (cnt_last) begin
              state <= ST_FIN;
            end
`endif
          end
        end
        ST_DRAIN: begin
`ifdef PRM_LOAD_ERR_EN
          if (beat && bus.src_last) begin
            state <= ST_FIN;
          end
`else
          state <= ST_IDLE;
`endif
        end
        ST_FIN: begin
          state     <= ST_IDLE;
          done      <= 1'b1;
          bus.prm_b <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prm_load_ctrl.sv
module tb_prm_load_ctrl;
  import tiny_dnn_pkg::*;

`ifdef PRM_LOAD_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       bmode = 1'b0;
  logic [9:0] ks = '0;
  logic [3:0] nf = '0;
  logic       busy, done, err;

  prm_load_ctrl_if bus ();

  prm_load_ctrl #(.F_NUM(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bmode (bmode),
    .ks    (ks),
    .nf    (nf),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // monitor: every write and done pulse, sampled on the falling edge
  int cyc = 0;
  int wr_v[$], wr_a[$], wr_wd[$], wr_b[$], wr_cyc[$];
  int done_cnt = 0;
  int done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.prm_we === 1'b1) begin
      wr_v.push_back(int'(bus.prm_v));
      wr_a.push_back(int'(bus.prm_a));
      wr_wd.push_back(int'(bus.prm_wd));
      wr_b.push_back(int'(bus.prm_b));
      wr_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  logic [15:0] data_sent [256];
  logic        alt_bm = 1'b0;
  logic [9:0]  alt_ks = '0;
  logic [3:0]  alt_nf = '0;
  logic        busy_at_done, err_at_done;

  // reference model: the write sequence a load should produce
  function automatic int m_total(bit bm, int k, int n);
    return bm ? (n + 1) : (n + 1) * (k + 1);
  endfunction

  function automatic int m_writes(bit bm, int k, int n, int li);
    int t = m_total(bm, k, n);
    if (ERR_EN && li >= 0 && li < t - 1) return li + 1;
    return t;
  endfunction

  function automatic int m_beats(bit bm, int k, int n, int li);
    int t = m_total(bm, k, n);
    if (ERR_EN && li > t - 1) return li + 1;
    return m_writes(bm, k, n, li);
  endfunction

  function automatic int m_v(bit bm, int k, int i);
    return bm ? i : i / (k + 1);
  endfunction

  function automatic int m_a(bit bm, int k, int i);
    return bm ? 0 : i % (k + 1);
  endfunction

  task automatic clear_mon();
    wr_v.delete(); wr_a.delete(); wr_wd.delete(); wr_b.delete(); wr_cyc.delete();
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) data_sent[i] = 16'($urandom);
  endtask

  // mode 0: valid always high, 1: toggles 1/0, 2: random
  task automatic drive_load(input bit do_start, input bit bm, input logic [9:0] k,
                            input logic [3:0] n, input int mode, input int last_idx,
                            input int max_beats, input bit hold_start,
                            output int acc, output bit tmo);
    int d0;
    int budget;
    bit tog;
    acc = 0; tmo = 1'b0; d0 = done_cnt; tog = 1'b1;
    if (do_start) begin
      @(posedge clk); #1;
      start = 1'b1; bmode = bm; ks = k; nf = n;
      @(posedge clk); #1;
      start = hold_start; bmode = alt_bm; ks = alt_ks; nf = alt_nf;
    end
    budget = 4000;
    while (1) begin
      case (mode)
        0: bus.src_valid = 1'b1;
        1: begin bus.src_valid = tog; tog = ~tog; end
        default: bus.src_valid = 1'($urandom_range(0, 1));
      endcase
      bus.src_data = {data_sent[acc & 255], 16'($urandom)};
      bus.src_last = (acc == last_idx);
      @(negedge clk); #1;
      if (bus.src_valid && bus.src_ready) acc++;
      if (done_cnt != d0) begin
        busy_at_done = busy;
        err_at_done = err;
        break;
      end
      if (max_beats > 0 && acc >= max_beats) break;
      budget--;
      if (budget == 0) begin tmo = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    bus.src_valid = 1'b0;
    bus.src_last = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_status: busy=%b done=%b err=%b required 0 0 0", busy, done, err); end
    checks++; if (bus.prm_we !== 1'b0 || bus.prm_b !== 1'b0 || bus.src_ready !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: we=%b b=%b ready=%b required 0 0 0", bus.prm_we, bus.prm_b, bus.src_ready); end
    checks++; if (bus.prm_v !== 4'd0 || bus.prm_a !== 10'd0 || bus.prm_wd !== 16'd0) begin
      errors++; $display("FAIL reset_data: v=%0d a=%0d wd=%h required 0 0 0", bus.prm_v, bus.prm_a, bus.prm_wd); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || bus.src_ready !== 1'b0) begin
      errors++; $display("FAIL reset_release: busy=%b ready=%b required 0 0", busy, bus.src_ready); end
  endtask

  task automatic test_weight_load();
    int acc, n; bit tmo;
    clear_mon(); fill_random();
    alt_bm = 1'b1; alt_ks = 10'd9; alt_nf = 4'd7;
    drive_load(1'b1, 1'b0, 10'd2, 4'd1, 0, 5, 0, 1'b0, acc, tmo);
    n = m_writes(1'b0, 2, 1, 5);
    checks++; if (tmo) begin errors++; $display("FAIL weight_timeout: no done within budget"); end
    checks++; if (wr_v.size() !== n) begin
      errors++; $display("FAIL weight_count: got %0d writes required %0d", wr_v.size(), n); end
    for (int i = 0; i < n && i < wr_v.size(); i++) begin
      checks++;
      if (wr_v[i] !== m_v(1'b0, 2, i) || wr_a[i] !== m_a(1'b0, 2, i) ||
          wr_wd[i] !== int'(data_sent[i]) || wr_b[i] !== 0) begin
        errors++; $display("FAIL weight_write %0d: got v=%0d a=%0d wd=%h b=%0d required v=%0d a=%0d wd=%h b=0",
          i, wr_v[i], wr_a[i], wr_wd[i], wr_b[i], m_v(1'b0, 2, i), m_a(1'b0, 2, i), data_sent[i]);
      end
    end
    if (wr_cyc.size() > 0) begin
      checks++; if (done_cyc !== wr_cyc[wr_cyc.size()-1] + 1) begin
        errors++; $display("FAIL weight_done_latency: done cycle %0d required %0d", done_cyc, wr_cyc[wr_cyc.size()-1] + 1); end
    end
    checks++; if (busy_at_done !== 1'b0 || err_at_done !== 1'b0) begin
      errors++; $display("FAIL weight_done_state: busy=%b err=%b required 0 0", busy_at_done, err_at_done); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b0 || bus.prm_we !== 1'b0) begin
      errors++; $display("FAIL weight_done_pulse: done=%b we=%b one cycle later, required 0 0", done, bus.prm_we); end
  endtask

  task automatic test_bias_load();
    int acc, n; bit tmo;
    clear_mon();
    for (int i = 0; i < 256; i++) data_sent[i] = 16'(i + 1);
    alt_bm = 1'b0; alt_ks = 10'd3; alt_nf = 4'd2;
    drive_load(1'b1, 1'b1, 10'd5, 4'd15, 0, 15, 0, 1'b0, acc, tmo);
    n = m_writes(1'b1, 5, 15, 15);
    checks++; if (tmo) begin errors++; $display("FAIL bias_timeout: no done within budget"); end
    checks++; if (wr_v.size() !== n) begin
      errors++; $display("FAIL bias_count: got %0d writes required %0d", wr_v.size(), n); end
    for (int i = 0; i < n && i < wr_v.size(); i++) begin
      checks++;
      if (wr_v[i] !== m_v(1'b1, 5, i) || wr_a[i] !== 0 || wr_wd[i] !== i + 1 || wr_b[i] !== 1) begin
        errors++; $display("FAIL bias_write %0d: got v=%0d a=%0d wd=%h b=%0d required v=%0d a=0 wd=%h b=1",
          i, wr_v[i], wr_a[i], wr_wd[i], wr_b[i], i, i + 1);
      end
    end
    checks++; if (bus.prm_b !== 1'b0) begin
      errors++; $display("FAIL bias_b_idle: prm_b=%b after load, required 0", bus.prm_b); end
  endtask

  task automatic test_toggle_valid();
    int acc, n; bit tmo;
    clear_mon(); fill_random();
    drive_load(1'b1, 1'b0, 10'd3, 4'd0, 1, 3, 0, 1'b0, acc, tmo);
    n = m_writes(1'b0, 3, 0, 3);
    checks++; if (tmo || acc !== 4) begin
      errors++; $display("FAIL toggle_beats: accepted %0d timeout=%0d required 4 timeout=0", acc, tmo); end
    checks++; if (wr_v.size() !== n) begin
      errors++; $display("FAIL toggle_count: got %0d writes required %0d", wr_v.size(), n); end
    for (int i = 0; i < n && i < wr_v.size(); i++) begin
      checks++;
      if (wr_v[i] !== 0 || wr_a[i] !== i || wr_wd[i] !== int'(data_sent[i])) begin
        errors++; $display("FAIL toggle_write %0d: got v=%0d a=%0d wd=%h required v=0 a=%0d wd=%h",
          i, wr_v[i], wr_a[i], wr_wd[i], i, data_sent[i]);
      end
    end
    if (wr_cyc.size() > 0) begin
      checks++; if (done_cyc !== wr_cyc[wr_cyc.size()-1] + 1) begin
        errors++; $display("FAIL toggle_done_latency: done cycle %0d required %0d", done_cyc, wr_cyc[wr_cyc.size()-1] + 1); end
    end
  endtask

  task automatic test_random_loads();
    int acc, n, t; bit tmo; bit bm; int k, f;
    for (int it = 0; it < 6; it++) begin
      clear_mon(); fill_random();
      bm = 1'($urandom_range(0, 1)); k = $urandom_range(0, 5); f = $urandom_range(0, 3);
      alt_bm = 1'($urandom_range(0, 1)); alt_ks = 10'($urandom); alt_nf = 4'($urandom);
      t = m_total(bm, k, f);
      drive_load(1'b1, bm, 10'(k), 4'(f), 2, t - 1, 0, 1'b0, acc, tmo);
      n = m_writes(bm, k, f, t - 1);
      checks++; if (tmo || wr_v.size() !== n || err !== 1'b0) begin
        errors++; $display("FAIL random_count it%0d: writes=%0d timeout=%0d err=%b required writes=%0d timeout=0 err=0",
          it, wr_v.size(), tmo, err, n); end
      for (int i = 0; i < n && i < wr_v.size(); i++) begin
        checks++;
        if (wr_v[i] !== m_v(bm, k, i) || wr_a[i] !== m_a(bm, k, i) ||
            wr_wd[i] !== int'(data_sent[i]) || wr_b[i] !== int'(bm)) begin
          errors++; $display("FAIL random_write it%0d #%0d: got v=%0d a=%0d wd=%h b=%0d required v=%0d a=%0d wd=%h b=%0d",
            it, i, wr_v[i], wr_a[i], wr_wd[i], wr_b[i], m_v(bm, k, i), m_a(bm, k, i), data_sent[i], bm);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int acc, n; bit tmo;
    clear_mon(); fill_random();
    drive_load(1'b1, 1'b0, 10'd7, 4'd0, 0, 7, 3, 1'b0, acc, tmo);
    @(negedge clk); #1;
    rst_n = 1'b0; #1;
    checks++; if (bus.prm_we !== 1'b0 || busy !== 1'b0 || bus.src_ready !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: we=%b busy=%b ready=%b done=%b required 0 0 0 0",
        bus.prm_we, busy, bus.src_ready, done); end
    checks++; if (bus.prm_v !== 4'd0 || bus.prm_a !== 10'd0 || bus.prm_wd !== 16'd0) begin
      errors++; $display("FAIL midrst_data: v=%0d a=%0d wd=%h required 0 0 0", bus.prm_v, bus.prm_a, bus.prm_wd); end
    bus.src_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    bus.src_valid = 1'b0;
    checks++; if (wr_v.size() !== 3 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_no_writes: writes=%0d busy=%b required 3 0", wr_v.size(), busy); end
    for (int i = 0; i < 3 && i < wr_v.size(); i++) begin
      checks++; if (wr_v[i] !== 0 || wr_a[i] !== i || wr_wd[i] !== int'(data_sent[i])) begin
        errors++; $display("FAIL midrst_write %0d: got v=%0d a=%0d wd=%h required v=0 a=%0d wd=%h",
          i, wr_v[i], wr_a[i], wr_wd[i], i, data_sent[i]); end
    end
    clear_mon(); fill_random();
    drive_load(1'b1, 1'b0, 10'd1, 4'd1, 0, 3, 0, 1'b0, acc, tmo);
    n = m_writes(1'b0, 1, 1, 3);
    checks++; if (tmo || wr_v.size() !== n) begin
      errors++; $display("FAIL midrst_reload_count: writes=%0d timeout=%0d required %0d 0", wr_v.size(), tmo, n); end
    for (int i = 0; i < n && i < wr_v.size(); i++) begin
      checks++; if (wr_v[i] !== m_v(1'b0, 1, i) || wr_a[i] !== m_a(1'b0, 1, i) || wr_wd[i] !== int'(data_sent[i])) begin
        errors++; $display("FAIL midrst_reload_write %0d: got v=%0d a=%0d wd=%h required v=%0d a=%0d wd=%h",
          i, wr_v[i], wr_a[i], wr_wd[i], m_v(1'b0, 1, i), m_a(1'b0, 1, i), data_sent[i]); end
    end
  endtask

  task automatic test_framing();
    int acc, n, nb; bit tmo;
    int lis[2] = '{1, 5};
    foreach (lis[c]) begin
      clear_mon(); fill_random();
      drive_load(1'b1, 1'b0, 10'd3, 4'd0, 0, lis[c], 0, 1'b0, acc, tmo);
      n = m_writes(1'b0, 3, 0, lis[c]);
      nb = m_beats(1'b0, 3, 0, lis[c]);
      checks++; if (tmo || wr_v.size() !== n || acc !== nb) begin
        errors++; $display("FAIL framing_counts last@%0d: writes=%0d beats=%0d timeout=%0d required writes=%0d beats=%0d timeout=0",
          lis[c], wr_v.size(), acc, tmo, n, nb); end
      checks++; if (err_at_done !== ERR_EN || err !== ERR_EN) begin
        errors++; $display("FAIL framing_err last@%0d: err at done=%b after=%b required %b", lis[c], err_at_done, err, ERR_EN); end
      for (int i = 0; i < n && i < wr_v.size(); i++) begin
        checks++; if (wr_a[i] !== i || wr_wd[i] !== int'(data_sent[i])) begin
          errors++; $display("FAIL framing_write last@%0d #%0d: got a=%0d wd=%h required a=%0d wd=%h",
            lis[c], i, wr_a[i], wr_wd[i], i, data_sent[i]); end
      end
    end
  endtask

  task automatic test_start_busy();
    int acc, n, k2; bit tmo;
    clear_mon(); fill_random();
    k2 = $urandom_range(0, 3);
    alt_bm = 1'b1; alt_ks = 10'(k2); alt_nf = 4'd2;
    drive_load(1'b1, 1'b0, 10'd1, 4'd1, 0, 1, 0, 1'b1, acc, tmo);
    n = m_writes(1'b0, 1, 1, 1);
    checks++; if (tmo || wr_v.size() !== n) begin
      errors++; $display("FAIL busy_first_count: writes=%0d timeout=%0d required %0d 0", wr_v.size(), tmo, n); end
    for (int i = 0; i < n && i < wr_v.size(); i++) begin
      checks++; if (wr_v[i] !== m_v(1'b0, 1, i) || wr_a[i] !== m_a(1'b0, 1, i) || wr_b[i] !== 0) begin
        errors++; $display("FAIL busy_first_write %0d: got v=%0d a=%0d b=%0d required v=%0d a=%0d b=0",
          i, wr_v[i], wr_a[i], wr_b[i], m_v(1'b0, 1, i), m_a(1'b0, 1, i)); end
    end
    checks++; if (busy_at_done !== 1'b0 || err_at_done !== ERR_EN) begin
      errors++; $display("FAIL busy_done_cycle: busy=%b err=%b required 0 %b", busy_at_done, err_at_done, ERR_EN); end
    checks++; if (busy !== 1'b1 || err !== 1'b0 || bus.prm_b !== 1'b1) begin
      errors++; $display("FAIL busy_restart: busy=%b err=%b prm_b=%b required 1 0 1", busy, err, bus.prm_b); end
    clear_mon(); fill_random();
    drive_load(1'b0, 1'b1, 10'(k2), 4'd2, 0, 2, 0, 1'b0, acc, tmo);
    n = m_writes(1'b1, k2, 2, 2);
    checks++; if (tmo || wr_v.size() !== n) begin
      errors++; $display("FAIL busy_second_count: writes=%0d timeout=%0d required %0d 0", wr_v.size(), tmo, n); end
    for (int i = 0; i < n && i < wr_v.size(); i++) begin
      checks++; if (wr_v[i] !== i || wr_a[i] !== 0 || wr_wd[i] !== int'(data_sent[i]) || wr_b[i] !== 1) begin
        errors++; $display("FAIL busy_second_write %0d: got v=%0d a=%0d wd=%h b=%0d required v=%0d a=0 wd=%h b=1",
          i, wr_v[i], wr_a[i], wr_wd[i], wr_b[i], i, data_sent[i]); end
    end
  endtask

  initial begin
    bus.src_valid = 1'b0;
    bus.src_data = '0;
    bus.src_last = 1'b0;
    test_reset();
    test_weight_load();
    test_bias_load();
    test_toggle_valid();
    test_random_loads();
    test_reset_mid_load();
    test_framing();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
